axil_sram_slave: RTL and testbench

AXIL_SRAM_SLAVE -- requirements
Module: axil_sram_slave

---
 rtl/cpu_types_pkg.sv | 43 ++++
 rtl/axi4_lite_if.sv | 42 ++++
 rtl/axil_lfsr16.sv | 35 +++
 rtl/axil_sram_slave.sv | 250 +++++++++++++++++++++++++
 tb/tb_axil_sram_slave.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types and constants for the AXI4-Lite SRAM responder:
//   - AXI response encodings (OKAY / DECERR)
//   - transaction FSM state enum
//   - LFSR seed used by the optional random-delay generator
//   - byte-lane merge helper used when committing a strobed write
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One transaction in flight: a read or a write is either waiting out its
  // latency or holding its response until the master takes it.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_RESP,
    S_WR_WAIT,
    S_WR_RESP
  } axil_state_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [AXI_DATA_W-1:0] apply_strb(
    input logic [AXI_DATA_W-1:0] old_word,
    input logic [AXI_DATA_W-1:0] new_word,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(AXI_STRB_W); i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// -----------------------------------------------------------------------------
// AXI4_Lite
// 32-bit AXI4-Lite bus bundle (no PROT signals).
// Modports:
//   slave  - responder side (drives the readies on AW/W/AR, the B and R channels)
//   master - requester side
// -----------------------------------------------------------------------------
interface AXI4_Lite;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_lfsr16.sv
// -----------------------------------------------------------------------------
// axil_lfsr16
// 16-bit Fibonacci LFSR (taps 16,14,13,11), stepping every cycle, reseeded to
// 16'hACE1 by reset. Only instantiated when AXIL_SRAM_RAND_DELAY_EN is defined.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   delay_o - low nibble of the LFSR state, used as a 0..15 latency
// -----------------------------------------------------------------------------
module axil_lfsr16
  import cpu_types_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] delay_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Tap numbers are 1-based, so tap 16 is bit 15, 14 is bit 13, and so on.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign delay_o = lfsr_q[3:0];

endmodule

// File: rtl/axil_sram_slave.sv
// -----------------------------------------------------------------------------
// axil_sram_slave
// AXI4-Lite responder backed by a word-wide SRAM array. One transaction is in
// flight at a time; reads take priority over writes when both are offered.
// Each accepted transaction waits a programmable number of cycles before its
// response is presented (rvalid / bvalid are registered, minimum one cycle).
// Addresses outside [MEM_BASE, MEM_BASE + 4*MEM_WORDS) return DECERR; reads
// then return zero and writes leave memory untouched.
//
// Parameters:
//   MEM_BASE  - byte address of word 0
//   MEM_WORDS - number of 32-bit words
//   RD_LAT    - read wait cycles, 0..15
//   WR_LAT    - write wait cycles, 0..15
// Ports:
//   clk    - single clock, all logic on posedge
//   rst    - synchronous active-high reset (memory contents are kept)
//   axi_if - AXI4_Lite.slave bus
// Configuration:
//   AXIL_SRAM_RAND_DELAY_EN - when defined, both latencies come from a free
//   running LFSR (0..15) sampled at accept instead of RD_LAT / WR_LAT.
// -----------------------------------------------------------------------------
module axil_sram_slave
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic      clk,
  input  logic      rst,
  AXI4_Lite.slave   axi_if
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // ---------------------------------------------------------------------------
  // Latency source
  // ---------------------------------------------------------------------------
  logic [3:0] rd_delay;
  logic [3:0] wr_delay;

`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [3:0] lfsr_delay;

  axil_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .delay_o (lfsr_delay)
  );

  assign rd_delay = lfsr_delay;
  assign wr_delay = lfsr_delay;
`else
  assign rd_delay = 4'(RD_LAT);
  assign wr_delay = 4'(WR_LAT);
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  axil_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;     // shared by read and write: no overlap
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  logic        arready;
  logic        awready;
  logic        wready;
  logic        rd_issue;           // present the read response this edge
  logic        wr_issue;           // commit the write and present bresp this edge
  logic        mem_we;

  logic [31:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Address decode on the latched address. The subtraction wraps for addresses
  // below MEM_BASE, so the lower bound is checked separately.
  // ---------------------------------------------------------------------------
  logic [31:0]      addr_off;
  logic [31:0]      word_off;
  logic             in_range;
  logic [IDX_W-1:0] mem_idx;

  assign addr_off = addr_q - MEM_BASE;
  assign word_off = addr_off >> 2;
  assign in_range = (addr_q >= MEM_BASE) && (word_off < 32'(MEM_WORDS));
  assign mem_idx  = word_off[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    arready  = 1'b0;
    awready  = 1'b0;
    wready   = 1'b0;
    rd_issue = 1'b0;
    wr_issue = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        arready = 1'b1;
        if (axi_if.arvalid) begin
          addr_d  = axi_if.araddr;
          cnt_d   = rd_delay;
          state_d = (rd_delay == 4'd0) ? S_RD_RESP : S_RD_WAIT;
        end else if (axi_if.awvalid && axi_if.wvalid) begin
          // AW and W are only ever taken together.
          awready = 1'b1;
          wready  = 1'b1;
          addr_d  = axi_if.awaddr;
          wdata_d = axi_if.wdata;
          wstrb_d = axi_if.wstrb;
          cnt_d   = wr_delay;
          state_d = (wr_delay == 4'd0) ? S_WR_RESP : S_WR_WAIT;
        end
      end

      S_RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d    = 4'd0;
          state_d  = S_RD_RESP;
          rd_issue = 1'b1;
        end
      end

      S_RD_RESP: begin
        // Zero-delay entry arrives here with rvalid still low; issuing now
        // keeps the minimum latency at one registered cycle.
        if (!rvalid_q) begin
          rd_issue = 1'b1;
        end else if (axi_if.rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d    = 4'd0;
          state_d  = S_WR_RESP;
          wr_issue = 1'b1;
        end
      end

      S_WR_RESP: begin
        if (!bvalid_q) begin
          wr_issue = 1'b1;
        end else if (axi_if.bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (rd_issue) begin
      rvalid_d = 1'b1;
      rdata_d  = in_range ? mem[mem_idx] : 32'h0;
      rresp_d  = in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR;
    end

    // The write lands on the same edge bvalid rises, so any read accepted
    // after b_fire sees the new data.
    if (wr_issue) begin
      bvalid_d = 1'b1;
      bresp_d  = in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR;
      mem_we   = in_range;
    end
  end

  // ---------------------------------------------------------------------------
  // Control and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      rresp_q  <= AXI_RESP_OKAY;
      bvalid_q <= 1'b0;
      bresp_q  <= AXI_RESP_OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset on purpose; contents must survive rst and a
  // reset port would stop it mapping onto RAM. Reset only suppresses a commit
  // that would otherwise land on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_idx] <= apply_strb(mem[mem_idx], wdata_q, wstrb_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus outputs
  // ---------------------------------------------------------------------------
  assign axi_if.arready = arready;
  assign axi_if.awready = awready;
  assign axi_if.wready  = wready;
  assign axi_if.rvalid  = rvalid_q;
  assign axi_if.rdata   = rdata_q;
  assign axi_if.rresp   = rresp_q;
  assign axi_if.bvalid  = bvalid_q;
  assign axi_if.bresp   = bresp_q;

endmodule

// File: tb/tb_axil_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_sram_slave
// Self-checking bench for axil_sram_slave (RD_LAT=3, WR_LAT=4, 4096 words at
// 0x8000_0000). Directed scenarios followed by randomized reads/writes, all
// compared against an associative-array memory model of known words.
// -----------------------------------------------------------------------------
module tb_axil_sram_slave;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          WORDS  = 4096;
  localparam int          RD_LAT = 3;
  localparam int          WR_LAT = 4;
  localparam int          BUDGET = 64;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] model_mem [int];

  AXI4_Lite bus ();

  axil_sram_slave #(
    .MEM_BASE  (BASE),
    .MEM_WORDS (WORDS),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .axi_if (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checking and reference model
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat, input int dly);
`ifdef AXIL_SRAM_RAND_DELAY_EN
    check(tag, 32'(lat >= 1 && lat <= 15), 32'd1);
`else
    check(tag, 32'(lat), 32'((dly < 1) ? 1 : dly));
`endif
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    longint la = longint'({32'h0, a});
    longint lb = longint'({32'h0, BASE});
    return (la >= lb) && (la < lb + 4 * longint'(WORDS));
  endfunction

  function automatic int model_index(input logic [31:0] a);
    return int'((longint'({32'h0, a}) - longint'({32'h0, BASE})) / 4);
  endfunction

  // Partial writes to a word whose prior contents are unknown leave it unknown.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int          w;
    logic [31:0] v;
    if (!model_in_range(a)) return;
    w = model_index(a);
    if (s == 4'hF) begin
      model_mem[w] = d;
    end else if (model_mem.exists(w)) begin
      v = model_mem[w];
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      model_mem[w] = v;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bus transactions: entered and left just after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < BUDGET) begin
      @(negedge clk); #1; n++;
    end
    check("ar_accept", 32'(bus.arready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < BUDGET) begin
      @(negedge clk); lat++;
    end
    check("rvalid_seen", 32'(bus.rvalid), 32'd1);
    data = bus.rdata;
    resp = bus.rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("r_hold_valid", 32'(bus.rvalid), 32'd1);
      check("r_hold_data", bus.rdata, data);
      check("r_hold_resp", 32'(bus.rresp), 32'(resp));
    end
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
    check("r_done", 32'(bus.rvalid), 32'd0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int hold, output logic [1:0] resp, output int lat);
    int n;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    #1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < BUDGET) begin
      @(negedge clk); #1; n++;
    end
    check("aw_accept", 32'(bus.awready), 32'd1);
    check("w_accept", 32'(bus.wready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    lat = 0;
    while (!bus.bvalid && lat < BUDGET) begin
      @(negedge clk); lat++;
    end
    check("bvalid_seen", 32'(bus.bvalid), 32'd1);
    resp = bus.bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("b_hold_valid", 32'(bus.bvalid), 32'd1);
    end
    bus.bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    check("b_done", 32'(bus.bvalid), 32'd0);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input int hold);
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat;
    int          w;
    axi_read(addr, hold, data, resp, lat);
    check_lat({tag, "_rlat"}, lat, RD_LAT);
    if (model_in_range(addr)) begin
      check({tag, "_rresp"}, 32'(resp), 32'(RESP_OKAY));
      w = model_index(addr);
      if (model_mem.exists(w)) check({tag, "_rdata"}, data, model_mem[w]);
    end else begin
      check({tag, "_rresp"}, 32'(resp), 32'(RESP_DECERR));
      check({tag, "_rdata"}, data, 32'h0);
    end
  endtask

  task automatic write_check(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int hold);
    logic [1:0] resp;
    int         lat;
    axi_write(addr, data, strb, hold, resp, lat);
    check_lat({tag, "_blat"}, lat, WR_LAT);
    check({tag, "_bresp"}, 32'(resp),
          32'(model_in_range(addr) ? RESP_OKAY : RESP_DECERR));
    model_write(addr, data, strb);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat;
    logic [31:0] addr;

    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_rresp", 32'(bus.rresp), 32'(RESP_OKAY));
    check("rst_bresp", 32'(bus.bresp), 32'(RESP_OKAY));
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_awready", 32'(bus.awready), 32'd0);
    @(negedge clk);

    // Full-word write then read back.
    axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, resp, lat);
    check("wr10_bresp", 32'(resp), 32'(RESP_OKAY));
    check_lat("wr10_blat", lat, WR_LAT);
    model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    axi_read(32'h8000_0010, 0, data, resp, lat);
    check("rd10_rdata", data, 32'hDEAD_BEEF);
    check("rd10_rresp", 32'(resp), 32'(RESP_OKAY));
    check_lat("rd10_rlat", lat, RD_LAT);

    // Single-lane strobe merges into the preloaded word.
    write_check("pre20", 32'h8000_0020, 32'h1122_3344, 4'hF, 0);
    write_check("strb20", 32'h8000_0020, 32'h00AA_0000, 4'b0100, 1);
    axi_read(32'h8000_0020, 0, data, resp, lat);
    check("strb20_rdata", data, 32'h11AA_3344);

    // rready held low: response must stay put.
    read_check("hold10", 32'h8000_0010, 5);

    // Decode boundaries.
    write_check("pre00", 32'h8000_0000, 32'hA5A5_0001, 4'hF, 0);
    read_check("oor_lo", 32'h7FFF_FFFC, 0);
    write_check("oor_hi", 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0);
    read_check("word0", 32'h8000_0000, 0);
    write_check("last", 32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF, 0);
    read_check("last_lowbits", 32'h8000_3FFF, 0);
    read_check("oor_hi_rd", 32'h8000_4000, 0);

    // Read and write offered together: read wins, write held off until r_fire.
    write_check("pre50", 32'h8000_0050, 32'h0BAD_F00D, 4'hF, 0);
    bus.araddr  = 32'h8000_0050;
    bus.arvalid = 1'b1;
    bus.awaddr  = 32'h8000_0050;
    bus.wdata   = 32'hCAFE_1234;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    #1;
    check("coll_arready", 32'(bus.arready), 32'd1);
    check("coll_awready", 32'(bus.awready), 32'd0);
    check("coll_wready", 32'(bus.wready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    #1;
    lat = 0;
    while (!bus.rvalid && lat < BUDGET) begin
      check("coll_wait_awready", 32'(bus.awready), 32'd0);
      @(negedge clk); #1; lat++;
    end
    check_lat("coll_rlat", lat, RD_LAT);
    check("coll_rdata", bus.rdata, 32'h0BAD_F00D);
    @(negedge clk); #1;
    check("coll_resp_awready", 32'(bus.awready), 32'd0);
    bus.rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
    write_check("coll_wr", 32'h8000_0050, 32'hCAFE_1234, 4'hF, 0);
    read_check("coll_after", 32'h8000_0050, 0);

    // Reset while the write is still waiting: nothing committed, no response.
    write_check("pre40", 32'h8000_0040, 32'h5555_AAAA, 4'hF, 0);
    bus.awaddr  = 32'h8000_0040;
    bus.wdata   = 32'h1234_5678;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    #1;
    check("rstwr_accept", 32'(bus.awready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("rstwr_waiting", 32'(bus.bvalid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstwr_arready", 32'(bus.arready), 32'd1);
    check("rstwr_bvalid", 32'(bus.bvalid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rstwr_no_b", 32'(bus.bvalid), 32'd0);
    end
    read_check("rstwr_kept", 32'h8000_0040, 0);

    // Randomized traffic over a small window plus out-of-range addresses.
    for (int k = 0; k < 8; k++) begin
      write_check("rnd_init", 32'h8000_0100 + 32'(4 * k), $urandom, 4'hF, 0);
    end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'h7FFF_FFFC - 32'(4 * $urandom_range(0, 3));
        1:       addr = 32'h8000_4000 + 32'(4 * $urandom_range(0, 3));
        default: addr = 32'h8000_0100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 1)
        write_check("rnd_wr", addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      else
        read_check("rnd_rd", addr, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
